// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive engine.
// Contents: rx_state FSM encoding, configuration limits, and a data-bit clamp helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE_S,
        RX_START_S,
        RX_DATA_S,
        RX_PARITY_S,
        RX_STOP_S,
        RX_BREAK_S
    } rx_state;

    localparam int unsigned MIN_CLKS_PER_BIT = 4;
    localparam int unsigned MIN_DATA_BITS    = 5;
    localparam int unsigned MAX_DATA_BITS    = 8;

    // Force a requested data-bit count into the supported 5..8 range.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
        if (bits < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end else if (bits > 4'(MAX_DATA_BITS)) begin
            return 4'(MAX_DATA_BITS);
        end else begin
            return bits;
        end
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus falling-edge detect.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (all flops reset to 1, the idle line level)
//   rx    in   raw serial line
//   rx_s  out  synchronised line
//   fall  out  1 for one cycle when rx_s goes 1 -> 0
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive engine: start-bit detect, mid-bit sampling, 5..8 data bits LSB-first,
// optional parity, stop bit, valid/ready output with per-frame error pulses.
// Optional feature macro: UART_RX_BREAK_DET_EN adds break detection and the break_det port.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx                  asynchronous serial input, idle high
//   cfg_clks_per_bit    clocks per bit (<4 treated as 4)
//   cfg_data_bits       data bits (clamped to 5..8)
//   cfg_parity_en/odd   parity enable / odd select
//   rx_data, rx_valid   received frame, held until rx_valid && rx_ready
//   rx_ready            consumer accept
//   parity_err          1-cycle pulse, parity mismatch
//   frame_err           1-cycle pulse, stop bit sampled 0
//   overrun_err         1-cycle pulse, frame completed while previous one unconsumed
//   busy                1 outside IDLE
//   break_det           1-cycle pulse on a break frame (UART_RX_BREAK_DET_EN only)
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [DIV_W-1:0]  cfg_clks_per_bit,
    input  logic [3:0]        cfg_data_bits,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic              break_det
`endif
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (rx_fall)
    );

    rx_state           state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  cpb_q;
    logic [3:0]        bits_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic              par_en_q;
    logic              odd_q;
    logic [DATA_W-1:0] data_q;
    logic              perr_q;

    logic [DIV_W-1:0]  cpb_eff;
    logic [3:0]        bits_eff;
    logic              last_bit;
    logic              is_break;

    always_comb begin
        cpb_eff  = (cfg_clks_per_bit < DIV_W'(MIN_CLKS_PER_BIT)) ?
                   DIV_W'(MIN_CLKS_PER_BIT) : cfg_clks_per_bit;
        bits_eff = clamp_data_bits(cfg_data_bits);
        last_bit = (bit_idx_q == IDX_W'(bits_q - 4'd1));
    end

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_q;
    // All data bits, parity bit (if any) and stop bit low.
    assign is_break = ~rx_s && (data_q == '0) && !(par_en_q && par_bit_q);
`else
    assign is_break = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RX_IDLE_S;
            cnt_q       <= '0;
            cpb_q       <= '0;
            bits_q      <= '0;
            bit_idx_q   <= '0;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q   <= 1'b0;
            break_det   <= 1'b0;
`endif
        end else begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det   <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state_q)
                RX_IDLE_S: begin
                    if (rx_fall) begin
                        // Half a bit period so the start bit is sampled mid-bit.
                        cnt_q   <= (cpb_eff >> 1) - DIV_W'(1);
                        state_q <= RX_START_S;
                        busy    <= 1'b1;
                    end
                end

                RX_START_S: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            state_q <= RX_IDLE_S;
                            busy    <= 1'b0;
                        end else begin
                            // Config is frozen here for the rest of the frame.
                            cpb_q     <= cpb_eff;
                            bits_q    <= bits_eff;
                            par_en_q  <= cfg_parity_en;
                            odd_q     <= cfg_parity_odd;
                            cnt_q     <= cpb_eff - DIV_W'(1);
                            bit_idx_q <= '0;
                            data_q    <= '0;
                            perr_q    <= 1'b0;
                            state_q   <= RX_DATA_S;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end

                RX_DATA_S: begin
                    if (cnt_q == '0) begin
                        data_q[bit_idx_q] <= rx_s;
                        cnt_q             <= cpb_q - DIV_W'(1);
                        if (last_bit) begin
                            state_q <= par_en_q ? RX_PARITY_S : RX_STOP_S;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end

                RX_PARITY_S: begin
                    if (cnt_q == '0) begin
                        perr_q  <= (^data_q) ^ rx_s ^ odd_q;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_q <= rx_s;
`endif
                        cnt_q   <= cpb_q - DIV_W'(1);
                        state_q <= RX_STOP_S;
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end

                RX_STOP_S: begin
                    if (cnt_q == '0) begin
                        if (is_break) begin
                            state_q   <= RX_BREAK_S;
`ifdef UART_RX_BREAK_DET_EN
                            break_det <= 1'b1;
`endif
                        end else begin
                            // Leave immediately so a back-to-back start edge is not missed.
                            state_q    <= RX_IDLE_S;
                            busy       <= 1'b0;
                            frame_err  <= ~rx_s;
                            parity_err <= perr_q;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= data_q;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end

`ifdef UART_RX_BREAK_DET_EN
                RX_BREAK_S: begin
                    if (rx_s) begin
                        state_q <= RX_IDLE_S;
                        busy    <= 1'b0;
                    end
                end
`endif

                default: begin
                    state_q <= RX_IDLE_S;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed vector table, hand-written corner
// sequences (overrun, glitch, mid-frame reset, break) and randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_fsm;

    localparam int DIV_W  = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx = 1'b1;
    logic [DIV_W-1:0]  cfg_clks_per_bit = 16'd16;
    logic [3:0]        cfg_data_bits = 4'd8;
    logic              cfg_parity_en = 1'b0;
    logic              cfg_parity_odd = 1'b0;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready = 1'b0;
    logic              parity_err;
    logic              frame_err;
    logic              overrun_err;
    logic              busy;
`ifdef UART_RX_BREAK_DET_EN
    logic              break_det;
`endif

    uart_rx_fsm #(
        .DIV_W  (DIV_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx               (rx),
        .cfg_clks_per_bit (cfg_clks_per_bit),
        .cfg_data_bits    (cfg_data_bits),
        .cfg_parity_en    (cfg_parity_en),
        .cfg_parity_odd   (cfg_parity_odd),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .parity_err       (parity_err),
        .frame_err        (frame_err),
        .overrun_err      (overrun_err),
        .busy             (busy)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .break_det        (break_det)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (parity_err)  perr_cnt++;
            if (frame_err)   ferr_cnt++;
            if (overrun_err) ovr_cnt++;
`ifdef UART_RX_BREAK_DET_EN
            if (break_det)   brk_cnt++;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        perr_cnt = 0;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        brk_cnt  = 0;
    endtask

    function automatic int eff_bits(input int b);
        return (b < 5) ? 5 : ((b > 8) ? 8 : b);
    endfunction

    function automatic int eff_cpb(input int c);
        return (c < 4) ? 4 : c;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Sends one complete frame starting at a negedge; leaves rx idle-high afterwards.
    task automatic send_frame(input logic [7:0] data, input int cfg_bits, input int cfg_cpb,
                              input bit par_en, input bit odd, input bit flip,
                              input bit stop, input bit scramble);
        int   nb;
        int   cpb;
        logic [7:0] mask;
        logic p;
        nb   = eff_bits(cfg_bits);
        cpb  = eff_cpb(cfg_cpb);
        mask = 8'((1 << nb) - 1);
        cfg_clks_per_bit = 16'(cfg_cpb);
        cfg_data_bits    = 4'(cfg_bits);
        cfg_parity_en    = par_en;
        cfg_parity_odd   = odd;
        drive_bit(1'b0, cpb);
        for (int i = 0; i < nb; i++) begin
            drive_bit(data[i], cpb);
            if (i == 0 && scramble) begin
                cfg_clks_per_bit = 16'($urandom_range(0, 40));
                cfg_data_bits    = 4'($urandom);
                cfg_parity_en    = 1'($urandom);
                cfg_parity_odd   = 1'($urandom);
            end
        end
        if (par_en) begin
            p = (^(data & mask)) ^ odd ^ flip;
            drive_bit(p, cpb);
        end
        drive_bit(stop, cpb);
        rx = 1'b1;
    endtask

    task automatic wait_idle(input int cpb);
        repeat (2 * eff_cpb(cpb) + 8) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp_data,
                               input bit exp_valid, input int exp_perr, input int exp_ferr,
                               input int exp_ovr, input int exp_brk);
        check({name, " rx_data"}, rx_data, exp_data);
        check({name, " rx_valid"}, rx_valid, exp_valid);
        check({name, " parity_err pulses"}, perr_cnt, exp_perr);
        check({name, " frame_err pulses"}, ferr_cnt, exp_ferr);
        check({name, " overrun_err pulses"}, ovr_cnt, exp_ovr);
        check({name, " break_det pulses"}, brk_cnt, exp_brk);
        check({name, " busy"}, busy, 0);
    endtask

    task automatic consume(input string name);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check({name, " rx_valid after handshake"}, rx_valid, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         bits;
        int         cpb;
        bit         par_en;
        bit         odd;
        bit         flip;
        bit         stop;
        logic [7:0] exp_data;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] last_data;
        logic [7:0] data;
        logic [7:0] masked;
        int         cb;
        int         cc;
        bit         pe;
        bit         od;
        bit         fl;
        bit         st;
        bit         pbit;
        bit         brk;

        vecs[0] = '{8'hA5, 8, 16, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 0};
        vecs[1] = '{8'h5A, 7, 16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 0, 0};
        vecs[2] = '{8'h5A, 7, 16, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1, 0};
        vecs[3] = '{8'h3C, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1};
        vecs[4] = '{8'hFF, 3,  2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1F, 0, 0};
        vecs[5] = '{8'hC3, 12, 5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1, 0};
        vecs[6] = '{8'h96, 6, 16, 1'b0, 1'b0, 1'b0, 1'b1, 8'h16, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset busy", busy, 0);
        check("reset flags", {parity_err, frame_err, overrun_err}, 0);

        // Directed vectors
        foreach (vecs[i]) begin
            clear_counts();
            send_frame(vecs[i].data, vecs[i].bits, vecs[i].cpb, vecs[i].par_en, vecs[i].odd,
                       vecs[i].flip, vecs[i].stop, 1'b0);
            wait_idle(vecs[i].cpb);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_data, 1'b1, vecs[i].exp_perr,
                        vecs[i].exp_ferr, 0, 0);
            consume($sformatf("vec%0d", i));
        end

        // Back-to-back frames with no consumer: second frame overruns
        clear_counts();
        send_frame(8'h11, 8, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 8, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(16);
        check_frame("overrun", 8'h11, 1'b1, 0, 0, 1, 0);
        consume("overrun");

`ifdef UART_RX_BREAK_DET_EN
        // Break: all-zero frame with stop 0, line held low afterwards
        clear_counts();
        cfg_clks_per_bit = 16'd16;
        cfg_data_bits    = 4'd8;
        cfg_parity_en    = 1'b0;
        drive_bit(1'b0, 16 * 10 + 48);
        check("break busy while line low", busy, 1);
        check("break rx_valid while low", rx_valid, 0);
        check("break_det pulses", brk_cnt, 1);
        check("break frame_err pulses", ferr_cnt, 0);
        rx = 1'b1;
        wait_idle(16);
        check("break busy after release", busy, 0);
        check("break rx_valid after release", rx_valid, 0);
        check("break rx_data unchanged", rx_data, 8'h22 & 8'h00 | 8'h11);
`endif

        // Start glitch shorter than half a bit
        clear_counts();
        cfg_clks_per_bit = 16'd16;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch busy during start", busy, 1);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        check("glitch busy after", busy, 0);
        check("glitch rx_valid", rx_valid, 0);
        check("glitch flags", perr_cnt + ferr_cnt + ovr_cnt, 0);
        send_frame(8'h80, 8, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(16);
        check_frame("after glitch", 8'h80, 1'b1, 0, 0, 0, 0);

        // Reset during data bit 3 (0x80 left unconsumed so reset must clear it)
        cfg_data_bits = 4'd8;
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16 * 3);
        drive_bit(1'b0, 8);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset rx_data", rx_data, 0);
        check("midreset rx_valid", rx_valid, 0);
        check("midreset busy", busy, 0);
        check("midreset flags", {parity_err, frame_err, overrun_err}, 0);
        clear_counts();
        send_frame(8'hFF, 8, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(16);
        check_frame("after reset", 8'hFF, 1'b1, 0, 0, 0, 0);
        consume("after reset");
        last_data = 8'hFF;

        // Randomized frames vs frame-level model
        for (int n = 0; n < 24; n++) begin
            data = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            cb   = $urandom_range(0, 15);
            cc   = $urandom_range(0, 24);
            pe   = 1'($urandom);
            od   = 1'($urandom);
            fl   = 1'($urandom);
            st   = ($urandom_range(0, 3) != 0);
            masked = data & 8'((1 << eff_bits(cb)) - 1);
            pbit   = (^masked) ^ od ^ fl;
            brk    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk = !st && (masked == 8'h00) && (!pe || !pbit);
`endif
            if (!brk) last_data = masked;
            clear_counts();
            send_frame(data, cb, cc, pe, od, fl, st, 1'b1);
            wait_idle(cc);
            check_frame($sformatf("rand%0d", n), last_data, !brk,
                        (pe && fl && !brk) ? 1 : 0, (!st && !brk) ? 1 : 0, 0, brk ? 1 : 0);
            consume($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
